// File: rtl/wb_regfile_if.sv
// Writeback-to-register-file bus: GPR write port, HI/LO write port,
// two GPR read ports and the HI/LO read-out. The pipeline side uses the
// master modport, the register file uses the slave modport.

`ifndef RegBus
`define RegBus 32
`endif
`ifndef RegAddrBus
`define RegAddrBus 5
`endif

interface wb_regfile_if;
  logic                     we;
  logic [`RegAddrBus-1:0]   waddr;
  logic [`RegBus-1:0]       wdata;
  logic                     whilo;
  logic [`RegBus-1:0]       hi_i;
  logic [`RegBus-1:0]       lo_i;
  logic                     re1;
  logic [`RegAddrBus-1:0]   raddr1;
  logic [`RegBus-1:0]       rdata1;
  logic                     re2;
  logic [`RegAddrBus-1:0]   raddr2;
  logic [`RegBus-1:0]       rdata2;
  logic [`RegBus-1:0]       hi_o;
  logic [`RegBus-1:0]       lo_o;

  modport master (
    output we, waddr, wdata, whilo, hi_i, lo_i,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  we, waddr, wdata, whilo, hi_i, lo_i,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );
endinterface

// File: rtl/wb_regfile.sv
// MIPS writeback register file: 31 writable GPRs ($0 reads as zero),
// HI/LO pair, two combinational GPR read ports and a HI/LO read-out.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a write
// presented this cycle is forwarded to matching readers in the same cycle.

`ifndef RegBus
`define RegBus 32
`endif
`ifndef RegAddrBus
`define RegAddrBus 5
`endif

module wb_regfile (
  input logic          clk,
  input logic          rst,
  wb_regfile_if.slave  bus
);

  localparam int NumRegs = 1 << `RegAddrBus;

  // Entry 0 is only ever cleared and never read, so it folds to a constant.
  logic [`RegBus-1:0] regs_reg [0:NumRegs-1];
  logic [`RegBus-1:0] hi_reg;
  logic [`RegBus-1:0] lo_reg;

  // GPR commit: reset clears everything, writes to $0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (bus.we && (bus.waddr != '0)) begin
      regs_reg[bus.waddr] <= bus.wdata;
    end
  end

  // HI/LO commit: both halves always written together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (bus.whilo) begin
      hi_reg <= bus.hi_i;
      lo_reg <= bus.lo_i;
    end
  end

  // Read port 1: reset, disable and $0 force zero ahead of any lookup.
  always_comb begin
    bus.rdata1 = '0;
    if (rst || !bus.re1 || (bus.raddr1 == '0)) begin
      bus.rdata1 = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (bus.we && (bus.waddr == bus.raddr1)) begin
      bus.rdata1 = bus.wdata;
`endif
    end else begin
      bus.rdata1 = regs_reg[bus.raddr1];
    end
  end

  // Read port 2: identical priority to port 1, fully independent.
  always_comb begin
    bus.rdata2 = '0;
    if (rst || !bus.re2 || (bus.raddr2 == '0)) begin
      bus.rdata2 = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (bus.we && (bus.waddr == bus.raddr2)) begin
      bus.rdata2 = bus.wdata;
`endif
    end else begin
      bus.rdata2 = regs_reg[bus.raddr2];
    end
  end

  // HI/LO read-out: zero in reset, otherwise stored (or forwarded) values.
  always_comb begin
    bus.hi_o = hi_reg;
    bus.lo_o = lo_reg;
    if (rst) begin
      bus.hi_o = '0;
      bus.lo_o = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (bus.whilo) begin
      bus.hi_o = bus.hi_i;
      bus.lo_o = bus.lo_i;
`endif
    end
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Architectural state sink at the writeback end of the five-stage MIPS pipeline. Holds the 32×32-bit general-purpose register file and the HI/LO pair, and commits the write-back stage's outputs on the clock edge. Serves two combinational GPR read ports to decode and one HI/LO read port to execute. Optionally forwards a same-cycle write-back value to readers.

## Interface
- Parameters: none. Widths come from the `RegBus` (32) and `RegAddrBus` (5) defines.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `we`  in  1  GPR write enable, driven by the write-back stage's register-write flag.
- `waddr`  in  5  GPR write address.
- `wdata`  in  32  GPR write data.
- `whilo`  in  1  HI/LO write enable.
- `hi_i`  in  32  HI write data.
- `lo_i`  in  32  LO write data.
- `re1`  in  1  read port 1 enable.
- `raddr1`  in  5  read port 1 address.
- `rdata1`  out  32  read port 1 data, combinational.
- `re2`  in  1  read port 2 enable.
- `raddr2`  in  5  read port 2 address.
- `rdata2`  out  32  read port 2 data, combinational.
- `hi_o`  out  32  current HI, combinational.
- `lo_o`  out  32  current LO, combinational.

## Operation
- **Storage:** `regs[1..31]` are 32-bit flops. `$0` is not stored.
- **GPR write:** on a rising edge with `rst=0`, `we=1` and `waddr!=0`, `regs[waddr] <= wdata`.
  - A write to address 0 is dropped silently.
  - With `we=0`, no register changes, whatever `waddr`/`wdata` hold.
- **HI/LO write:** on a rising edge with `rst=0` and `whilo=1`, HI and LO are both updated from `hi_i`/`lo_i`.
  - There is no split HI-only or LO-only write. Instructions that write only one half supply the other half's current value upstream.
- **Reset:** every rising edge with `rst=1` clears `regs[1..31]`, HI and LO to 0. Reset wins over any simultaneous `we` or `whilo`.
- **Read port n (`rdata1` / `rdata2`), evaluated in priority order:**
  1. `rst=1` → 0.
  2. `ren=0` → 0.
  3. `raddrn=0` → 0.
  4. Bypass hit (see Configuration) → `wdata`.
  5. Otherwise → `regs[raddrn]`.
- **Dual reads:** both ports are independent. Reading the same address on both ports in the same cycle is legal and returns identical data.
- **HI/LO read (`hi_o` / `lo_o`):**
  - `rst=1` → 0.
  - Bypass hit (`whilo=1`, see Configuration) → `hi_i` / `lo_i`.
  - Otherwise → stored HI / LO.

## Timing
- **Write latency:** 1 cycle. Data presented in cycle N is stored at the end of cycle N and visible from stored state in cycle N+1.
- **Read latency:** 0 cycles, purely combinational from the address, enable and state.
- **Write-back stall bubbles:** these arrive as `we=0`, `whilo=0` and must cause no state change. A held stall holds the state for any number of cycles.
- **Reset values:**
  - All storage is 0 after the first reset edge.
  - `rdata1`, `rdata2`, `hi_o` and `lo_o` read 0 for as long as `rst` is high, independent of storage.
- **Reset mid-operation:** a write presented in the same cycle as `rst=1` is lost. The first post-reset write needs `rst=0` at its edge.

## Configuration
- **Macro:** `REGFILE_BYPASS_EN`.
- **Defined:**
  - A read with `we=1`, `waddr==raddrn` and `waddr!=0` returns `wdata` in the same cycle.
  - HI/LO outputs return `hi_i`/`lo_i` whenever `whilo=1`.
  - This removes the write-back-to-decode hazard.
- **Undefined:**
  - Reads always return stored state, so a same-cycle write is seen one cycle later.
  - The pipeline controller must then insert one extra stall on that hazard.
  - No other behaviour changes.

## Test plan
- **Reset:**
  - Stimulus: hold `rst=1` for 2 cycles with `we=1`, `waddr=5`, `wdata=32'hDEADBEEF`, `re1=1`, `raddr1=5`.
  - Required: `rdata1=0` throughout. After release with `we=0`, `rdata1=0` and `hi_o=lo_o=0`.
- **Write then read:**
  - Stimulus: write `32'h12345678` to `$7`, then next cycle `re1=1`, `raddr1=7`, `re2=1`, `raddr2=7`.
  - Required: `rdata1=rdata2=32'h12345678`. Both ports read 0 with `re1=re2=0`.
- **`$0` protection:**
  - Stimulus: write `32'hFFFFFFFF` to address 0, then read address 0 on both ports.
  - Required: 0 on both ports, including in the write cycle with bypass enabled.
- **Bypass:**
  - Stimulus: `$3` holds `32'hA`. In one cycle, `we=1`, `waddr=3`, `wdata=32'hB`, `raddr1=3`, `re1=1`.
  - Required: with `REGFILE_BYPASS_EN`, `rdata1=32'hB` in that cycle; without it, `32'hA` then `32'hB` the next cycle.
- **HI/LO:**
  - Stimulus: `whilo=1`, `hi_i=32'h1`, `lo_i=32'h2` for one cycle, then `whilo=0` with `hi_i=lo_i=32'h99` for 3 cycles.
  - Required: `hi_o=1`, `lo_o=2` held for all 3 cycles. During the write cycle, outputs are 1/2 with bypass and the old values without.
- **Stall bubbles:**
  - Stimulus: after filling `$1..$31` with their index, drive 10 cycles of `we=0` with random `waddr`/`wdata`.
  - Required: reading every address returns its index.
